fifo_uart_tx: RTL and testbench

- Downstream consumer of the 8-entry byte FIFO. Pops one byte whenever the FIFO is non-empty and serialises it as an 8N1 UART frame on `tx`.
- Frame format: start bit, 8 data bits LSB-first, 1 stop bit.
- Contains an oversampling baud tick generator.
- Sits between the FIFO and the board TX pin in the UART loopback/counter datapath.

---
 rtl/uart_pkg.sv | 9 +
 rtl/baud_tick_gen.sv | 45 ++++
 rtl/fifo_uart_tx.sv | 132 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator: one-cycle tick every CLK_FREQ/(BAUD*16) clocks,
// with a synchronous clear that restarts the count from zero.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("baud_tick_gen: clock divider must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from a show-ahead FIFO and shifts them
// out LSB-first, each bit lasting 16 baud ticks.
module fifo_uart_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_rd,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    import uart_pkg::*;

    generate
        if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_os_check
            $error("fifo_uart_tx: oversampling is fixed at 16");
        end
    endgenerate

    localparam int TICK_W = $clog2(uart_pkg::OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(uart_pkg::OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    tx_state_t              state_q, state_d;
    logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   tick;
    logic                   tick_clr;
    logic                   bit_end;

    baud_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    assign bit_end = tick && (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        done_d     = 1'b0;
        tick_clr   = 1'b0;
        fifo_rd    = 1'b0;

        if (state_q != IDLE && tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                // Gated by rst_n so a held reset never pops the FIFO.
                if (!fifo_empty && rst_n) begin
                    fifo_rd  = 1'b1;
                    shift_d  = fifo_rdata;
                    tick_clr = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is registered, so it is derived from the upcoming state.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_done = done_q;
    assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: a queue models the show-ahead FIFO and
// each frame is checked against the 8N1 bit pattern computed from the byte.
module tb_fifo_uart_tx;

    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD       = 10_000;
    localparam int BIT_CLKS   = 160;
    localparam int FRAME_CLKS = 1600;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rdata = 8'h00;
    logic       fifo_rd;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int checks = 0;
    int failures = 0;
    int cycleCnt = 0;
    int pops = 0;
    int rdWhileEmpty = 0;
    int rdWhileBusy = 0;

    logic [7:0] fifoQ[$];
    logic sTx, sRd, sBusy, sDone;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    task automatic driveFifo();
        fifo_empty = (fifoQ.size() == 0);
        fifo_rdata = (fifoQ.size() == 0) ? 8'h00 : fifoQ[0];
    endtask

    // One clock: sample outputs on the falling edge, then apply the FIFO pop.
    task automatic step();
        @(negedge clk);
        cycleCnt++;
        sTx = tx;
        sRd = fifo_rd;
        sBusy = tx_busy;
        sDone = tx_done;
        if (sRd && fifo_empty) rdWhileEmpty++;
        if (sRd && sBusy) rdWhileBusy++;
        @(posedge clk);
        #1;
        if (sRd === 1'b1 && fifoQ.size() > 0) begin
            void'(fifoQ.pop_front());
            pops++;
        end
        driveFifo();
    endtask

    // Waits for a start edge, then records the level of each of the 10 bit periods.
    task automatic rxFrame(input int disturbAt, output bit got, output logic [9:0] levels,
                           output bit stable, output int fallCycle, output int doneCycle,
                           output bit doneEarly);
        got = 0;
        stable = 1;
        doneEarly = 0;
        doneCycle = -1;
        fallCycle = -1;
        levels = '0;
        for (int w = 0; w < 3000; w++) begin
            step();
            if (sTx === 1'b0) begin
                got = 1;
                break;
            end
        end
        if (!got) return;
        fallCycle = cycleCnt;
        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < BIT_CLKS; k++) begin
                if (!(p == 0 && k == 0)) step();
                if (disturbAt == p * BIT_CLKS + k) begin
                    fifoQ.delete();
                    driveFifo();
                end
                if (sDone === 1'b1) doneEarly = 1;
                if (k == 0) levels[p] = sTx;
                else if (sTx !== levels[p]) stable = 0;
            end
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (sDone === 1'b1) begin
                doneCycle = cycleCnt;
                break;
            end
        end
    endtask

    function automatic logic [9:0] frameOf(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        fifoQ.push_back(8'h5A);
        driveFifo();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (sTx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx cycle %0d: got %b expected 1", i, sTx); end
            checks++;
            if (sRd !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd cycle %0d: got %b expected 0", i, sRd); end
            checks++;
            if (sBusy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy cycle %0d: got %b expected 0", i, sBusy); end
        end
        checks++;
        if (pops !== 0) begin failures++; $display("[TB] FAIL reset_pops: got %0d expected 0", pops); end
        fifoQ.delete();
        driveFifo();
        rst_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_single_byte();
        bit got, stable, early;
        logic [9:0] lv;
        int fall, done, p0, pushCycle;
        p0 = pops;
        fifoQ.push_back(8'hA5);
        driveFifo();
        step();
        pushCycle = cycleCnt;
        checks++;
        if (sRd !== 1'b1) begin failures++; $display("[TB] FAIL single_rd_latency: got %b expected 1", sRd); end
        rxFrame(-1, got, lv, stable, fall, done, early);
        checks++;
        if (!got) begin failures++; $display("[TB] FAIL single_start: got none expected start bit"); return; end
        checks++;
        if (fall !== pushCycle + 1) begin failures++; $display("[TB] FAIL single_tx_latency: got %0d expected %0d", fall - pushCycle, 1); end
        checks++;
        if (lv !== frameOf(8'hA5)) begin failures++; $display("[TB] FAIL single_bits: got %b expected %b", lv, frameOf(8'hA5)); end
        checks++;
        if (!stable) begin failures++; $display("[TB] FAIL single_bit_width: got unstable expected %0d clk per bit", BIT_CLKS); end
        checks++;
        if (done - fall !== FRAME_CLKS) begin failures++; $display("[TB] FAIL single_done_delay: got %0d expected %0d", done - fall, FRAME_CLKS); end
        checks++;
        if (early) begin failures++; $display("[TB] FAIL single_done_early: got 1 expected 0"); end
        checks++;
        if (pops - p0 !== 1) begin failures++; $display("[TB] FAIL single_pops: got %0d expected 1", pops - p0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[3] = '{8'h00, 8'hFF, 8'h3C};
        bit got, stable, early;
        logic [9:0] lv;
        int fall, done, p0, prevDone;
        p0 = pops;
        prevDone = -1;
        foreach (bytes[i]) fifoQ.push_back(bytes[i]);
        driveFifo();
        for (int f = 0; f < 3; f++) begin
            rxFrame(-1, got, lv, stable, fall, done, early);
            checks++;
            if (!got) begin failures++; $display("[TB] FAIL b2b_start%0d: got none expected start bit", f); return; end
            checks++;
            if (lv !== frameOf(bytes[f]) || !stable) begin
                failures++;
                $display("[TB] FAIL b2b_frame%0d: got %b stable=%0d expected %b", f, lv, stable, frameOf(bytes[f]));
            end
            if (f > 0) begin
                checks++;
                if (fall - prevDone !== 1) begin failures++; $display("[TB] FAIL b2b_gap%0d: got %0d expected 1", f, fall - prevDone); end
            end
            prevDone = done;
        end
        checks++;
        if (pops - p0 !== 3) begin failures++; $display("[TB] FAIL b2b_pops: got %0d expected 3", pops - p0); end
        checks++;
        if (fifo_empty !== 1'b1 || fifoQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL b2b_fifo_empty: got %b (%0d left) expected 1", fifo_empty, fifoQ.size());
        end
    endtask

    task automatic test_random_bytes();
        bit got, stable, early;
        logic [9:0] lv;
        logic [7:0] b;
        int fall, done;
        for (int n = 0; n < 4; n++) begin
            b = 8'($urandom_range(0, 255));
            fifoQ.push_back(b);
            driveFifo();
            rxFrame(-1, got, lv, stable, fall, done, early);
            checks++;
            if (!got || lv !== frameOf(b) || !stable) begin
                failures++;
                $display("[TB] FAIL random_frame%0d: got %b stable=%0d expected %b", n, lv, stable, frameOf(b));
            end
            checks++;
            if (done - fall !== FRAME_CLKS) begin failures++; $display("[TB] FAIL random_done%0d: got %0d expected %0d", n, done - fall, FRAME_CLKS); end
        end
    endtask

    task automatic test_data_change();
        bit got, stable, early;
        logic [9:0] lv;
        int fall, done, p0;
        p0 = pops;
        fifoQ.push_back(8'hC3);
        fifoQ.push_back(8'h77);
        driveFifo();
        rxFrame(300, got, lv, stable, fall, done, early);
        checks++;
        if (!got || lv !== frameOf(8'hC3) || !stable) begin
            failures++;
            $display("[TB] FAIL change_frame: got %b stable=%0d expected %b", lv, stable, frameOf(8'hC3));
        end
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (pops - p0 !== 1) begin failures++; $display("[TB] FAIL change_pops: got %0d expected 1", pops - p0); end
        checks++;
        if (sBusy !== 1'b0) begin failures++; $display("[TB] FAIL change_idle: got busy=%b expected 0", sBusy); end
    endtask

    task automatic test_reset_mid_frame();
        bit got, stable, early;
        logic [9:0] lv;
        int fall, done, p0;
        bit seen = 0;
        fifoQ.push_back(8'h55);
        driveFifo();
        for (int w = 0; w < 3000; w++) begin
            step();
            if (sTx === 1'b0) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("[TB] FAIL midreset_start: got none expected start bit"); return; end
        for (int i = 0; i < 5 * BIT_CLKS + 80 - 1; i++) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_async: got tx=%b busy=%b done=%b expected 1 0 0", tx, tx_busy, tx_done);
        end
        p0 = pops;
        fifoQ.push_back(8'h55);
        driveFifo();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (sRd !== 1'b0 || sDone !== 1'b0) begin failures++; $display("[TB] FAIL midreset_hold%0d: got rd=%b done=%b expected 0 0", i, sRd, sDone); end
        end
        rst_n = 1'b1;
        rxFrame(-1, got, lv, stable, fall, done, early);
        checks++;
        if (!got || lv !== frameOf(8'h55) || !stable) begin
            failures++;
            $display("[TB] FAIL midreset_frame: got %b stable=%0d expected %b", lv, stable, frameOf(8'h55));
        end
        checks++;
        if (early) begin failures++; $display("[TB] FAIL midreset_stale_done: got 1 expected 0"); end
        checks++;
        if (done - fall !== FRAME_CLKS) begin failures++; $display("[TB] FAIL midreset_done: got %0d expected %0d", done - fall, FRAME_CLKS); end
        checks++;
        if (pops - p0 !== 1) begin failures++; $display("[TB] FAIL midreset_pops: got %0d expected 1", pops - p0); end
    endtask

    task automatic test_empty_stall();
        int bad = 0;
        int p0;
        p0 = pops;
        fifoQ.delete();
        driveFifo();
        for (int i = 0; i < 2000; i++) begin
            step();
            if (sTx !== 1'b1 || sRd !== 1'b0 || sBusy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("[TB] FAIL stall_idle: got %0d bad cycles expected 0", bad); end
        checks++;
        if (pops !== p0) begin failures++; $display("[TB] FAIL stall_pops: got %0d expected 0", pops - p0); end
    endtask

    task automatic test_pop_rules();
        checks++;
        if (rdWhileEmpty !== 0) begin failures++; $display("[TB] FAIL rd_while_empty: got %0d expected 0", rdWhileEmpty); end
        checks++;
        if (rdWhileBusy !== 0) begin failures++; $display("[TB] FAIL rd_while_busy: got %0d expected 0", rdWhileBusy); end
    endtask

    initial begin
        #2;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_random_bytes();
        test_data_change();
        test_reset_mid_frame();
        test_empty_stall();
        test_pop_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
